up_down_counter: RTL and testbench



---
 rtl/up_down_counter.sv | 38 +++
 tb/tb_up_down_counter.sv | 99 +++++++++
 2 files changed

// File: rtl/up_down_counter.sv
// Loadable, enable-gated up/down counter with registered output.
// WRAP selects modulo wrap-around (1) or saturation at 0 / all-ones (0).
module up_down_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic at_max, at_min;
  assign at_max = (count == MAX);
  assign at_min = (count == '0);

  // Priority: reset, load, step; saturation only blocks the step itself.
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (set)
      count <= set_value;
    else if (enable) begin
      if (up_down) begin
        if (WRAP || !at_max) count <= count + ONE;
      end else begin
        if (WRAP || !at_min) count <= count - ONE;
      end
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench: drives a wrapping and a saturating counter with shared stimulus.
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       set = 1'b0;
  logic [3:0] set_value = 4'h0;
  logic       up_down = 1'b0;
  logic [3:0] count_w, count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  up_down_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .set(set),
    .set_value(set_value), .up_down(up_down), .count(count_w)
  );

  up_down_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .set(set),
    .set_value(set_value), .up_down(up_down), .count(count_s)
  );

  // Apply inputs at the falling edge, sample 1ns after the next rising edge.
  task automatic cyc(input string tag, input logic r, input logic s, input logic [3:0] sv,
                     input logic e, input logic ud,
                     input logic [3:0] exp_w, input logic [3:0] exp_s);
    @(negedge clk);
    reset = r; set = s; set_value = sv; enable = e; up_down = ud;
    @(posedge clk);
    #1;
    checks++;
    assert (count_w === exp_w) else begin
      errors++;
      $error("FAIL %s wrap: got %h expected %h", tag, count_w, exp_w);
    end
    checks++;
    assert (count_s === exp_s) else begin
      errors++;
      $error("FAIL %s sat: got %h expected %h", tag, count_s, exp_s);
    end
  endtask

  initial begin
    // 1. reset dominates set and enable
    for (int i = 0; i < 5; i++) cyc("reset_hold", 0, 1, 4'h5, 1, 1, 4'h0, 4'h0);
    cyc("reset_release", 1, 0, 4'h5, 0, 1, 4'h0, 4'h0);
    cyc("reset_release", 1, 0, 4'h5, 0, 1, 4'h0, 4'h0);

    // 2. load and hold
    cyc("load_0", 1, 1, 4'h0, 0, 0, 4'h0, 4'h0);
    cyc("load_a", 1, 1, 4'hA, 0, 0, 4'hA, 4'hA);
    for (int i = 0; i < 3; i++) cyc("hold_a", 1, 0, 4'h0, 0, 1, 4'hA, 4'hA);

    // 3. up then down, then hold
    cyc("load_0b", 1, 1, 4'h0, 0, 0, 4'h0, 4'h0);
    cyc("up1", 1, 0, 4'h0, 1, 1, 4'h1, 4'h1);
    cyc("up2", 1, 0, 4'h0, 1, 1, 4'h2, 4'h2);
    cyc("up3", 1, 0, 4'h0, 1, 1, 4'h3, 4'h3);
    cyc("up4", 1, 0, 4'h0, 1, 1, 4'h4, 4'h4);
    cyc("up5", 1, 0, 4'h0, 1, 1, 4'h5, 4'h5);
    cyc("dn4", 1, 0, 4'h0, 1, 0, 4'h4, 4'h4);
    cyc("dn3", 1, 0, 4'h0, 1, 0, 4'h3, 4'h3);
    cyc("dn2", 1, 0, 4'h0, 1, 0, 4'h2, 4'h2);
    cyc("dn1", 1, 0, 4'h0, 1, 0, 4'h1, 4'h1);
    cyc("dn0", 1, 0, 4'h0, 1, 0, 4'h0, 4'h0);
    cyc("hold0", 1, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    cyc("hold0", 1, 0, 4'h0, 0, 1, 4'h0, 4'h0);

    // 4. top and bottom boundaries
    cyc("load_e", 1, 1, 4'hE, 0, 0, 4'hE, 4'hE);
    cyc("up_f", 1, 0, 4'h0, 1, 1, 4'hF, 4'hF);
    cyc("up_wrap", 1, 0, 4'h0, 1, 1, 4'h0, 4'hF);
    cyc("up_past", 1, 0, 4'h0, 1, 1, 4'h1, 4'hF);
    cyc("load_1", 1, 1, 4'h1, 0, 0, 4'h1, 4'h1);
    cyc("dn_0", 1, 0, 4'h0, 1, 0, 4'h0, 4'h0);
    cyc("dn_wrap", 1, 0, 4'h0, 1, 0, 4'hF, 4'h0);
    cyc("dn_past", 1, 0, 4'h0, 1, 0, 4'hE, 4'h0);

    // 5. load beats step
    cyc("load_5", 1, 1, 4'h5, 0, 0, 4'h5, 4'h5);
    cyc("prio_load", 1, 1, 4'h3, 1, 1, 4'h3, 4'h3);
    cyc("prio_after", 1, 0, 4'h3, 1, 1, 4'h4, 4'h4);

    // 6. reset mid-count, then resume from 0
    cyc("load_6", 1, 1, 4'h6, 0, 0, 4'h6, 4'h6);
    cyc("up_7", 1, 0, 4'h0, 1, 1, 4'h7, 4'h7);
    cyc("mid_reset", 0, 0, 4'h0, 1, 1, 4'h0, 4'h0);
    cyc("resume1", 1, 0, 4'h0, 1, 1, 4'h1, 4'h1);
    cyc("resume2", 1, 0, 4'h0, 1, 1, 4'h2, 4'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
